// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem reads, buffers returned words and
// handles MIPS delay-slot redirects. Define IFETCH_PERF_EN to add perf counter outputs.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] instr,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        SEQ     = 2'd0,
        DS_WAIT = 2'd1,
        REDIR   = 2'd2
    } state_t;

    logic [31:0]          buf_pc_r    [BUF_DEPTH];
    logic [31:0]          buf_instr_r [BUF_DEPTH];
    logic [PW-1:0]        head_r, tail_r;
    logic [CW-1:0]        count_r;
    logic [31:0]          ifq_pc_r    [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] ifq_kill_r;
    logic [PW-1:0]        ifq_rd_r, ifq_wr_r;
    logic [CW-1:0]        outst_r;
    logic [31:0]          fetch_pc_r, target_r;
    logic                 req_hold_r;
    state_t               state_r;

    logic [31:0]          head_pc_s, head_instr_s, pc4_s, jump_tgt_s, fetch_pc_s, target_s;
    logic [CW:0]          occ_s;
    logic                 pop_s, redir_s, case_a_s, case_b_s, case_c_s, fire_s, push_s;
    logic [BUF_DEPTH-1:0] kill_s;
    state_t               state_s;

    assign head_pc_s    = buf_pc_r[head_r];
    assign head_instr_s = buf_instr_r[head_r];
    assign pc4_s        = head_pc_s + 32'd4;
    assign instr_valid  = (count_r != CW'(0));
    assign pc           = instr_valid ? head_pc_s : fetch_pc_r;
    assign instr        = instr_valid ? head_instr_s : 32'h0000_0000;

    assign pop_s   = instr_valid & ~stall;
    assign redir_s = pop_s & (jump_reg | jump_target | jump_branch);
    // Where the delay-slot word lives: a = buffered, b = in flight, c = not yet requested
    assign case_a_s = redir_s & (count_r > CW'(1));
    assign case_b_s = redir_s & (count_r == CW'(1)) & (outst_r != CW'(0));
    assign case_c_s = redir_s & (count_r == CW'(1)) & (outst_r == CW'(0));

    // The slot freed by this cycle's pop may be reused; an unaccepted request stays up.
    assign occ_s          = {1'b0, count_r} + {1'b0, outst_r} - {{CW{1'b0}}, pop_s};
    assign imem_req_valid = rst_n & (state_r != REDIR) &
                            ((occ_s < (CW+1)'(BUF_DEPTH)) | req_hold_r);
    assign imem_req_addr  = fetch_pc_r;
    assign fire_s         = imem_req_valid & imem_req_ready;
    assign push_s         = imem_resp_valid & ~ifq_kill_r[ifq_rd_r] & ~case_a_s;

    // Redirect target selection, jump_reg has highest priority
    always_comb begin
        jump_tgt_s = 32'h0000_0000;
        if (jump_reg) begin
            jump_tgt_s = jr_pc;
        end else if (jump_target) begin
            jump_tgt_s = {pc4_s[31:28], head_instr_s[25:0], 2'b00};
        end else begin
            jump_tgt_s = pc4_s + {{14{head_instr_s[15]}}, head_instr_s[15:0], 2'b00};
        end
    end

    // Squash marks for in-flight reads; only the delay-slot read survives a redirect
    always_comb begin
        kill_s = ifq_kill_r;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (fire_s && (PW'(i) == ifq_wr_r)) begin
                kill_s[i] = case_a_s | case_b_s;
            end else if (case_a_s || (case_b_s && (PW'(i) != ifq_rd_r))) begin
                kill_s[i] = 1'b1;
            end else begin
                kill_s[i] = ifq_kill_r[i];
            end
        end
    end

    // Fetch FSM next state and fetch_pc update
    always_comb begin
        state_s  = state_r;
        target_s = target_r;
        if (fire_s) begin
            fetch_pc_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_s = fetch_pc_r;
        end
        case (state_r)
            SEQ: begin
                if (case_a_s || case_b_s || (case_c_s && fire_s)) begin
                    fetch_pc_s = jump_tgt_s;
                end else if (case_c_s) begin
                    state_s  = DS_WAIT;
                    target_s = jump_tgt_s;
                end else begin
                    state_s = SEQ;
                end
            end
            DS_WAIT: begin
                if (fire_s) begin
                    state_s = REDIR;
                end else begin
                    state_s = DS_WAIT;
                end
            end
            REDIR: begin
                fetch_pc_s = target_r;
                state_s    = SEQ;
            end
            default: state_s = SEQ;
        endcase
    end

    // Control state: pointers, occupancy, squash marks, FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r     <= PW'(0);
            tail_r     <= PW'(0);
            count_r    <= CW'(0);
            ifq_rd_r   <= PW'(0);
            ifq_wr_r   <= PW'(0);
            outst_r    <= CW'(0);
            ifq_kill_r <= {BUF_DEPTH{1'b0}};
            fetch_pc_r <= RESET_PC;
            target_r   <= RESET_PC;
            req_hold_r <= 1'b0;
            state_r    <= SEQ;
        end else begin
            head_r <= head_r + PW'(pop_s);
            if (case_a_s) begin
                tail_r  <= head_r + PW'(2);
                count_r <= CW'(1);
            end else begin
                tail_r  <= tail_r + PW'(push_s);
                count_r <= count_r - CW'(pop_s) + CW'(push_s);
            end
            ifq_wr_r   <= ifq_wr_r + PW'(fire_s);
            ifq_rd_r   <= ifq_rd_r + PW'(imem_resp_valid);
            outst_r    <= outst_r + CW'(fire_s) - CW'(imem_resp_valid);
            ifq_kill_r <= kill_s;
            fetch_pc_r <= fetch_pc_s;
            target_r   <= target_s;
            req_hold_r <= imem_req_valid & ~imem_req_ready;
            state_r    <= state_s;
        end
    end

    // Payload storage for buffered words and in-flight request pcs
    always_ff @(posedge clk) begin
        if (push_s) begin
            buf_pc_r[tail_r]    <= ifq_pc_r[ifq_rd_r];
            buf_instr_r[tail_r] <= imem_resp_data;
        end
        if (fire_s) begin
            ifq_pc_r[ifq_wr_r] <= fetch_pc_r;
        end
    end

`ifdef IFETCH_PERF_EN
    // Performance counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_bubbles <= 32'd0;
        end else begin
            perf_fetched <= perf_fetched + {31'd0, push_s};
            perf_bubbles <= perf_bubbles + {31'd0, ~instr_valid & ~stall};
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: imem model with variable latency and a program-order
// reference stream (expected pc sequence incl. delay slot) checked at every consume.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] pc, instr;
    logic        stall, jump_branch, jump_target, jump_reg;
    logic [31:0] jr_pc;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .pc(pc), .instr(instr),
        .stall(stall), .jump_branch(jump_branch), .jump_target(jump_target),
        .jump_reg(jump_reg), .jr_pc(jr_pc)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] fires[$];
    logic [31:0] exp_pc, pend_tgt, prev_addr, stall_pc, dj_pc, dj_jr;
    bit          has_pend, prev_blocked, prev_redir, prev_stall, last_req_valid;
    bit          rnd_mode, stall_force, block_en;
    logic [31:0] block_addr, hold_addr;
    int          hold_left, fixed_lat, dj_kind, consumed, first_fire_cyc, first_valid_cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0020) return 32'h1000_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle; entered and left at a negedge
    task automatic step();
        int          kind;
        bit          consume, fire;
        logic [31:0] jr_val, ins, pc4, tgt;
        kind = 0;
        jr_val = 32'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(q_addr[0]);
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
        end
        stall = stall_force || (rnd_mode && ($urandom_range(0, 3) == 0));
        consume = instr_valid && !stall;
        if (consume && !has_pend) begin
            if (dj_kind != 0 && pc == dj_pc) begin
                kind = dj_kind;
                jr_val = dj_jr;
                dj_kind = 0;
            end else if (rnd_mode && ($urandom_range(0, 5) == 0)) begin
                kind = $urandom_range(1, 3);
                jr_val = $urandom & 32'hFFFF_FFFC;
            end
        end
        jump_branch = (kind == 1);
        jump_target = (kind == 2);
        jump_reg    = (kind == 3);
        jr_pc       = jr_val;
        #1;
        imem_req_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (block_en && imem_req_addr == block_addr) imem_req_ready = 1'b0;
        if (hold_left > 0 && imem_req_valid && imem_req_addr == hold_addr) begin
            imem_req_ready = 1'b0;
            hold_left--;
        end
        fire = imem_req_valid && imem_req_ready;

        if (instr_valid) begin
            chk("instr", instr, mem_word(pc));
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end else begin
            chk("nop", instr, 32'h0);
        end
        if (prev_blocked && !prev_redir) begin
            chk("hold_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("hold_addr", imem_req_addr, prev_addr);
        end
        if (stall_force && instr_valid) begin
            if (prev_stall) chk("stall_pc", pc, stall_pc);
            stall_pc = pc;
        end
        prev_stall     = stall_force && instr_valid;
        prev_blocked   = imem_req_valid && !imem_req_ready;
        prev_addr      = imem_req_addr;
        prev_redir     = consume && (kind != 0);
        last_req_valid = imem_req_valid;
        if (fire) begin
            q_addr.push_back(imem_req_addr);
            q_due.push_back(cyc + (rnd_mode ? int'($urandom_range(1, 3)) : fixed_lat));
            fires.push_back(imem_req_addr);
            if (first_fire_cyc < 0) first_fire_cyc = cyc;
        end
        if (consume) begin
            chk("pc", pc, exp_pc);
            consumed++;
            ins = mem_word(exp_pc);
            pc4 = exp_pc + 32'd4;
            if (kind != 0) begin
                case (kind)
                    3:       tgt = jr_val;
                    2:       tgt = {pc4[31:28], ins[25:0], 2'b00};
                    default: tgt = pc4 + {{14{ins[15]}}, ins[15:0], 2'b00};
                endcase
                has_pend = 1'b1;
                pend_tgt = tgt;
                exp_pc   = pc4;
            end else if (has_pend) begin
                exp_pc   = pend_tgt;
                has_pend = 1'b0;
            end else begin
                exp_pc = pc4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        stall = 1'b0; jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0;
        jr_pc = 32'h0;
        q_addr.delete();
        q_due.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        rst_n = 1'b1;
        exp_pc = 32'h0; has_pend = 1'b0; prev_blocked = 1'b0; prev_redir = 1'b0;
        prev_stall = 1'b0; fires.delete(); cyc = 0; consumed = 0;
        first_fire_cyc = -1; first_valid_cyc = -1;
    endtask

    task automatic run_until_dj(input string tag, input int budget);
        for (int i = 0; i < budget && dj_kind != 0; i++) step();
        chk(tag, 32'(dj_kind), 32'd0);
    endtask

    initial begin
        rnd_mode = 1'b0; stall_force = 1'b0; block_en = 1'b0; hold_left = 0;
        fixed_lat = 1; dj_kind = 0; block_addr = 32'h0; hold_addr = 32'h0;
        dj_pc = 32'h0; dj_jr = 32'h0;
        do_reset();

        // Sequential start, ready held low 3 cycles at 0x10, BEQ at 0x20
        hold_addr = 32'h10; hold_left = 3;
        dj_pc = 32'h20; dj_kind = 1;
        repeat (6) step();
        chk("first_reqs0", fires[0], 32'h0);
        chk("first_reqs1", fires[1], 32'h4);
        chk("first_reqs2", fires[2], 32'h8);
        chk("first_valid_lat", 32'(first_valid_cyc - first_fire_cyc), 32'd2);
        chk("one_per_cycle", 32'(consumed), 32'd4);
        run_until_dj("beq_taken", 60);

        // JR at 0x40 with 0x44 not yet requested, latency 3
        fixed_lat = 3; block_addr = 32'h44; block_en = 1'b1;
        dj_pc = 32'h40; dj_kind = 3; dj_jr = 32'h100;
        run_until_dj("jr_taken", 80);
        block_en = 1'b0;

        // JR to the top of the address space to exercise pc wrap
        fixed_lat = 1;
        dj_pc = 32'h108; dj_kind = 3; dj_jr = 32'hFFFF_FFF8;
        run_until_dj("jr_wrap_taken", 60);
        repeat (14) step();
        chk("wrap_progress", {31'd0, (exp_pc < 32'h40)}, 32'd1);

        // Stall with buffer full
        stall_force = 1'b1;
        repeat (6) step();
        chk("stall_req_valid", {31'd0, last_req_valid}, 32'd0);
        stall_force = 1'b0;
        repeat (6) step();

        // Randomised traffic
        rnd_mode = 1'b1;
        repeat (1500) step();
        rnd_mode = 1'b0;
        stall_force = 1'b0;
        for (int i = 0; i < 40 && has_pend; i++) step();

        // Reset with two reads in flight
        fixed_lat = 3;
        for (int i = 0; i < 30 && q_addr.size() != 2; i++) step();
        chk("mid_outstanding", 32'(q_addr.size()), 32'd2);
        do_reset();
        fixed_lat = 1;
        repeat (6) step();
        chk("restart_addr", fires[0], 32'h0);
        chk("restart_consumed", 32'(consumed), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
